// File: rtl/vx_mem_responder.sv
// rtl/vx_mem_responder.sv - line-addressed backing store with fixed-latency in-order read responses
module vx_mem_responder #(
  parameter int DATA_WIDTH     = 512,
  parameter int ADDR_WIDTH     = 26,
  parameter int TAG_WIDTH      = 8,
  parameter int SIZE_WIDTH     = 6,
  parameter int MEM_LINES_LOG2 = 10,
  parameter int LATENCY        = 4,
  parameter int RSP_DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      mem_req_valid,
  input  logic                      mem_req_rw,
  input  logic [DATA_WIDTH/8-1:0]   mem_req_byteen,
  input  logic [SIZE_WIDTH-1:0]     mem_req_size,
  input  logic [ADDR_WIDTH-1:0]     mem_req_addr,
  input  logic [DATA_WIDTH-1:0]     mem_req_data,
  input  logic [TAG_WIDTH-1:0]      mem_req_tag,
  output logic                      mem_req_ready,
  output logic                      mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]     mem_rsp_data,
  output logic [TAG_WIDTH-1:0]      mem_rsp_tag,
  input  logic                      mem_rsp_ready,
  output logic                      busy
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LINES = 1 << MEM_LINES_LOG2;
  localparam int CW    = $clog2(RSP_DEPTH + 1);
  localparam int PW    = $clog2(RSP_DEPTH);

  logic [DATA_WIDTH-1:0]     mem [LINES];
  logic [CW-1:0]             credits;
  logic [MEM_LINES_LOG2-1:0] line_idx;
  logic                      req_fire;
  logic                      wr_fire;
  logic                      rd_fire;
  logic                      rsp_fire;
  logic [DATA_WIDTH-1:0]     rd_data;

  logic                      push_valid;
  logic [DATA_WIDTH-1:0]     push_data;
  logic [TAG_WIDTH-1:0]      push_tag;
  logic                      push_ok;

  logic [DATA_WIDTH-1:0]     fifo_data [RSP_DEPTH];
  logic [TAG_WIDTH-1:0]      fifo_tag  [RSP_DEPTH];
  logic [PW-1:0]             rd_ptr;
  logic [PW-1:0]             wr_ptr;
  logic [CW-1:0]             count;
  logic                      fifo_full;

  // Size and the aliased upper address bits carry no meaning for a line-granular store.
  logic unused_ok;
  assign unused_ok = ^{mem_req_size, mem_req_addr[ADDR_WIDTH-1:MEM_LINES_LOG2]};

  // Nothing is accepted while reset is asserted, even though ready may read high.
  assign line_idx      = mem_req_addr[MEM_LINES_LOG2-1:0];
  assign mem_req_ready = (credits < CW'(RSP_DEPTH));
  assign req_fire      = mem_req_valid && mem_req_ready && reset_n;
  assign wr_fire       = req_fire && mem_req_rw;
  assign rd_fire       = req_fire && !mem_req_rw;
  assign rsp_fire      = mem_rsp_valid && mem_rsp_ready;
  assign busy          = (credits != '0);
  assign rd_data       = mem[line_idx];

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : PW'(p + 1'b1);
  endfunction

  // Byte-masked line write; the store is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < BYTES; i++) begin
        if (mem_req_byteen[i]) mem[line_idx][i*8 +: 8] <= mem_req_data[i*8 +: 8];
      end
    end
  end

  // The FIFO itself registers one stage, so the delay line holds LATENCY-1 stages.
  generate
    if (LATENCY == 1) begin : g_no_pipe
      assign push_valid = rd_fire;
      assign push_data  = rd_data;
      assign push_tag   = mem_req_tag;
    end else begin : g_pipe
      localparam int PS = LATENCY - 1;
      logic [PS-1:0]         pv;
      logic [DATA_WIDTH-1:0] pd [PS];
      logic [TAG_WIDTH-1:0]  pt [PS];

      // Valid bits of the non-stalling delay line.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          pv <= '0;
        end else begin
          pv[0] <= rd_fire;
          for (int i = 1; i < PS; i++) pv[i] <= pv[i-1];
        end
      end

      // Payload of the delay line follows the valids without reset.
      always_ff @(posedge clk) begin
        pd[0] <= rd_data;
        pt[0] <= mem_req_tag;
        for (int i = 1; i < PS; i++) begin
          pd[i] <= pd[i-1];
          pt[i] <= pt[i-1];
        end
      end

      assign push_valid = pv[PS-1];
      assign push_data  = pd[PS-1];
      assign push_tag   = pt[PS-1];
    end
  endgenerate

  // A push into a full FIFO is dropped; credits make it unreachable.
  assign fifo_full = (count == CW'(RSP_DEPTH));
  assign push_ok   = push_valid && (!fifo_full || rsp_fire);

  // FIFO pointers and occupancy; full+push+pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)  wr_ptr <= ptr_next(wr_ptr);
      if (rsp_fire) rd_ptr <= ptr_next(rd_ptr);
      case ({push_ok, rsp_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_data[wr_ptr] <= push_data;
      fifo_tag[wr_ptr]  <= push_tag;
    end
  end

  assign mem_rsp_valid = (count != '0);
  assign mem_rsp_data  = fifo_data[rd_ptr];
  assign mem_rsp_tag   = fifo_tag[rd_ptr];

  // Credits count reads anywhere between acceptance and response handshake.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      credits <= '0;
    end else begin
      case ({rd_fire, rsp_fire})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push_valid && fifo_full && !rsp_fire));

endmodule
